vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 18 +
 rtl/vend_if.sv | 25 ++
 rtl/vend_change.sv | 18 +
 rtl/vend_ctrl.sv | 84 ++++++++
 tb/tb_vend_ctrl.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: coin codes, FSM state codes and coin value decoding for vend_ctrl
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_5    = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_VEND    = 2'd2;
    localparam logic [1:0] ST_CHANGE  = 2'd3;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        return code == COIN_5 ? 3'd5 : {1'b0, code};
    endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: customer-side signals of vend_ctrl; cancel exists only with VEND_CANCEL_EN
interface vend_if #(parameter int N_PROD = 2);

    localparam int SEL_W = N_PROD > 1 ? $clog2(N_PROD) : 1;

    logic [1:0]       coin_in;
    logic [SEL_W-1:0] sel;
`ifdef VEND_CANCEL_EN
    logic             cancel;
`endif
    logic             soda;
    logic [SEL_W-1:0] soda_id;
    logic [1:0]       coin_out;
    logic             coin_rej;
    logic             busy;

`ifdef VEND_CANCEL_EN
    modport master(output coin_in, sel, cancel, input soda, soda_id, coin_out, coin_rej, busy);
    modport slave(input coin_in, sel, cancel, output soda, soda_id, coin_out, coin_rej, busy);
`else
    modport master(output coin_in, sel, input soda, soda_id, coin_out, coin_rej, busy);
    modport slave(input coin_in, sel, output soda, soda_id, coin_out, coin_rej, busy);
`endif

endinterface

// File: rtl/vend_change.sv
// vend_change: next change coin and matching remainder decrement, largest coin first
module vend_change
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic [CREDIT_W-1:0] rem,
    output logic [1:0]          coin,
    output logic [CREDIT_W-1:0] dec
);

    // pay out a 2-unit coin while possible, then the last single unit
    always_comb begin
        coin = 32'(rem) >= 2 ? COIN_2 : rem != '0 ? COIN_1 : COIN_NONE;
        dec  = CREDIT_W'(coin_value(coin));
    end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller; optional refund via VEND_CANCEL_EN
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int                          N_PROD   = 2,
    parameter int                          PRICE_W  = 4,
    parameter logic [N_PROD*PRICE_W-1:0]   PRICES   = {4'd4, 4'd3},
    parameter int                          CREDIT_W = 5
) (
    input logic  clk,
    input logic  reset,
    vend_if.slave bus
);

    localparam int SEL_W      = N_PROD > 1 ? $clog2(N_PROD) : 1;
    localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;

    logic [1:0]          state, state_n;
    logic [CREDIT_W-1:0] credit, credit_n, acc, leave_rem, chg_dec;
    logic [SEL_W-1:0]    prod_r, prod_n, sel_n;
    logic                rej_r, rej_n, refused, vend_go, cancel_go, busy_s;
    logic [2:0]          val;
    logic [31:0]         sum;
    logic [1:0]          chg_coin;
    logic [PRICE_W-1:0]  price;
    logic [PRICE_W-1:0]  price_tab [N_PROD];

    for (genvar i = 0; i < N_PROD; i++) begin : g_price
        assign price_tab[i] = PRICES[i*PRICE_W +: PRICE_W];
    end

    vend_change #(.CREDIT_W(CREDIT_W)) u_change (
        .rem  (credit),
        .coin (chg_coin),
        .dec  (chg_dec)
    );

    // next-state decode: accept coins and check price while collecting, settle credit while busy
    always_comb begin
        busy_s    = state == ST_VEND || state == ST_CHANGE;
        val       = coin_value(bus.coin_in);
        sum       = 32'(credit) + 32'(val);
        refused   = sum > CREDIT_MAX;
        acc       = refused ? credit : CREDIT_W'(sum);
        sel_n     = 32'(bus.sel) >= N_PROD ? '0 : bus.sel;
        price     = price_tab[sel_n];
        vend_go   = 32'(acc) >= 32'(price);
`ifdef VEND_CANCEL_EN
        cancel_go = state == ST_COLLECT && bus.cancel;
`else
        cancel_go = 1'b0;
`endif
        leave_rem = credit - CREDIT_W'(price_tab[prod_r]);
        credit_n  = state == ST_VEND ? leave_rem : state == ST_CHANGE ? credit - chg_dec : acc;
        state_n   = busy_s ? (credit_n != '0 ? ST_CHANGE : ST_IDLE)
                  : vend_go ? ST_VEND
                  : acc == '0 ? ST_IDLE
                  : cancel_go ? ST_CHANGE : ST_COLLECT;
        prod_n    = !busy_s && vend_go ? sel_n : prod_r;
        rej_n     = !busy_s && refused;
    end

    // state registers; reset discards credit and any pending change
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            credit <= '0;
            prod_r <= '0;
            rej_r  <= 1'b0;
        end else begin
            state  <= state_n;
            credit <= credit_n;
            prod_r <= prod_n;
            rej_r  <= rej_n;
        end
    end

    assign bus.soda     = state == ST_VEND;
    assign bus.soda_id  = state == ST_VEND ? prod_r : '0;
    assign bus.coin_out = state == ST_CHANGE ? chg_coin : COIN_NONE;
    assign bus.coin_rej = rej_r;
    assign bus.busy     = busy_s;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed checks of vend_ctrl (default build and VEND_CANCEL_EN build)
module tb_vend_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vend_if #(.N_PROD(2)) b1();
    vend_if #(.N_PROD(2)) b2();

    vend_ctrl u1 (.clk(clk), .reset(reset), .bus(b1.slave));

    vend_ctrl #(
        .N_PROD(2), .PRICE_W(3), .PRICES({3'd7, 3'd7}), .CREDIT_W(3)
    ) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [1:0] c, input logic s);
        b1.coin_in = c;
        b1.sel = s;
        tick();
        b1.coin_in = 2'b00;
    endtask

    task automatic drive2(input logic [1:0] c);
        b2.coin_in = c;
        tick();
        b2.coin_in = 2'b00;
    endtask

    task automatic outs1(input string tag, input int soda, input int id, input int co, input int rej, input int busy);
        check({tag, ".soda"}, 32'(b1.soda), 32'(soda));
        check({tag, ".soda_id"}, 32'(b1.soda_id), 32'(id));
        check({tag, ".coin_out"}, 32'(b1.coin_out), 32'(co));
        check({tag, ".coin_rej"}, 32'(b1.coin_rej), 32'(rej));
        check({tag, ".busy"}, 32'(b1.busy), 32'(busy));
    endtask

    initial begin
        b1.coin_in = 2'b00;
        b1.sel = 1'b0;
        b2.coin_in = 2'b00;
        b2.sel = 1'b0;
`ifdef VEND_CANCEL_EN
        b1.cancel = 1'b0;
        b2.cancel = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        outs1("reset", 0, 0, 0, 0, 0);
        check("reset.b2_busy", 32'(b2.busy), 0);

        // product 0 for exactly its price
        drive1(2'b10, 1'b0);
        outs1("p0_coin2", 0, 0, 0, 0, 0);
        drive1(2'b01, 1'b0);
        outs1("p0_vend", 1, 0, 0, 0, 1);
        drive1(2'b00, 1'b0);
        outs1("p0_idle", 0, 0, 0, 0, 0);

        // product 1 with a 5-unit coin, one unit change
        drive1(2'b11, 1'b1);
        outs1("p1_vend", 1, 1, 0, 0, 1);
        drive1(2'b00, 1'b1);
        outs1("p1_change", 0, 0, 1, 0, 1);
        drive1(2'b00, 1'b1);
        outs1("p1_idle", 0, 0, 0, 0, 0);

        // credit 6 on product 0: change 2 then 1; coin during change ignored
        drive1(2'b01, 1'b0);
        drive1(2'b11, 1'b0);
        outs1("c6_vend", 1, 0, 0, 0, 1);
        drive1(2'b00, 1'b0);
        outs1("c6_chg2", 0, 0, 2, 0, 1);
        drive1(2'b11, 1'b0);
        outs1("c6_chg1", 0, 0, 1, 0, 1);
        drive1(2'b00, 1'b0);
        outs1("c6_idle", 0, 0, 0, 0, 0);
        drive1(2'b10, 1'b0);
        outs1("c6_nocarry", 0, 0, 0, 0, 0);
        drive1(2'b01, 1'b0);
        outs1("c6_vend2", 1, 0, 0, 0, 1);
        drive1(2'b00, 1'b0);

        // reset during the first change cycle discards the remainder
        drive1(2'b01, 1'b0);
        drive1(2'b11, 1'b0);
        drive1(2'b00, 1'b0);
        outs1("rst_chg", 0, 0, 2, 0, 1);
        reset = 1'b1;
        b1.coin_in = 2'b11;
        tick();
        reset = 1'b0;
        b1.coin_in = 2'b00;
        outs1("rst_after", 0, 0, 0, 0, 0);
        drive1(2'b01, 1'b0);
        outs1("rst_collect", 0, 0, 0, 0, 0);
        drive1(2'b10, 1'b0);
        outs1("rst_vend", 1, 0, 0, 0, 1);
        drive1(2'b00, 1'b0);
        outs1("rst_idle", 0, 0, 0, 0, 0);

`ifdef VEND_CANCEL_EN
        // refund of a 2-unit credit; coin during refund is ignored
        drive1(2'b10, 1'b0);
        b1.cancel = 1'b1;
        tick();
        b1.cancel = 1'b0;
        outs1("cancel_refund", 0, 0, 2, 0, 1);
        drive1(2'b11, 1'b0);
        outs1("cancel_idle", 0, 0, 0, 0, 0);
        drive1(2'b10, 1'b0);
        outs1("cancel_clean", 0, 0, 0, 0, 0);
        drive1(2'b01, 1'b0);
        outs1("cancel_vend", 1, 0, 0, 0, 1);
        drive1(2'b00, 1'b0);
`else
        // credit persists while waiting in COLLECT
        drive1(2'b01, 1'b1);
        repeat (5) drive1(2'b00, 1'b1);
        outs1("persist_wait", 0, 0, 0, 0, 0);
        drive1(2'b11, 1'b1);
        outs1("persist_vend", 1, 1, 0, 0, 1);
        drive1(2'b00, 1'b1);
        outs1("persist_chg", 0, 0, 2, 0, 1);
        drive1(2'b00, 1'b1);
        outs1("persist_idle", 0, 0, 0, 0, 0);
`endif

        // narrow credit: overflowing coin refused, credit kept
        drive2(2'b10);
        check("ovf_c1.rej", 32'(b2.coin_rej), 0);
        drive2(2'b10);
        check("ovf_c2.soda", 32'(b2.soda), 0);
        drive2(2'b11);
        check("ovf_rej.rej", 32'(b2.coin_rej), 1);
        check("ovf_rej.soda", 32'(b2.soda), 0);
        drive2(2'b00);
        check("ovf_pulse.rej", 32'(b2.coin_rej), 0);
        drive2(2'b10);
        check("ovf_c6.soda", 32'(b2.soda), 0);
        drive2(2'b01);
        check("ovf_vend.soda", 32'(b2.soda), 1);
        check("ovf_vend.busy", 32'(b2.busy), 1);
        drive2(2'b00);
        check("ovf_idle.busy", 32'(b2.busy), 0);
        check("ovf_idle.coin_out", 32'(b2.coin_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
